// File: rtl/epsilon_pkg.sv
// ============================================================================
// epsilon_pkg : shared types and constants for the epsilon bitstream source
// Revision    : 1.0
// ============================================================================
`default_nettype none

package epsilon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  MODE_LFSR = 2'd0;
  localparam logic [1:0]  MODE_ZERO = 2'd1;
  localparam logic [1:0]  MODE_ONE  = 2'd2;
  localparam logic [1:0]  MODE_ALT  = 2'd3;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, shifting right
  localparam int unsigned LFSR_TAP_A = 0;
  localparam int unsigned LFSR_TAP_B = 2;
  localparam int unsigned LFSR_TAP_C = 3;
  localparam int unsigned LFSR_TAP_D = 5;

  function automatic logic lfsr_feedback(input logic [15:0] v);
    return v[LFSR_TAP_A] ^ v[LFSR_TAP_B] ^ v[LFSR_TAP_C] ^ v[LFSR_TAP_D];
  endfunction

endpackage

`default_nettype wire

// File: rtl/epsilon_lfsr16.sv
// ============================================================================
// epsilon_lfsr16 : 16-bit right-shifting Fibonacci LFSR with load and advance
// Revision       : 1.0
// ============================================================================
`default_nettype none

module epsilon_lfsr16
  import epsilon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic        bit_out
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (adv) begin
      r_lfsr <= {lfsr_feedback(r_lfsr), r_lfsr[15:1]};
    end
  end

  assign bit_out = r_lfsr[0];

endmodule

`default_nettype wire

// File: rtl/epsilon_stream_gen.sv
// ============================================================================
// epsilon_stream_gen : block-based test bitstream source with ones counting
// Revision           : 1.0
// ============================================================================
`default_nettype none

module epsilon_stream_gen
  import epsilon_pkg::*;
#(
  parameter int BLOCK_LEN = 128,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [15:0]      seed,
  input  logic             ready,
  output logic             epsilon_rsc_dat,
  output logic             epsilon_vld,
  output logic             block_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_count
);

  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [15:0]      r_seed;
  logic [CNT_W-1:0] r_bitcnt;
  logic [CNT_W-1:0] r_ones;
  logic             r_alt;
  logic             w_lfsr_bit;
  logic             w_bit;
  logic             w_run;
  logic             w_xfer;
  logic             w_last;

  assign w_run  = (r_state == ST_RUN);
  assign w_xfer = w_run & ready;
  assign w_last = (r_bitcnt == c_LAST_IDX);

  always_comb begin
    w_bit = 1'b0;
    case (r_mode)
      MODE_LFSR: w_bit = w_lfsr_bit;
      MODE_ZERO: w_bit = 1'b0;
      MODE_ONE:  w_bit = 1'b1;
      MODE_ALT:  w_bit = r_alt;
      default:   w_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_RUN;
      ST_RUN:  if (w_xfer && w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_LFSR;
      r_seed   <= LFSR_DEFAULT_SEED;
      r_bitcnt <= '0;
      r_ones   <= '0;
      r_alt    <= 1'b1;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_mode <= mode;
        r_seed <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
      end
      if (r_state == ST_LOAD) begin
        r_bitcnt <= '0;
        r_ones   <= '0;
        r_alt    <= 1'b1;
      end else if (w_xfer) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        r_ones   <= r_ones + CNT_W'(w_bit);
        r_alt    <= ~r_alt;
      end
    end
  end

  epsilon_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (r_state == ST_LOAD),
    .seed    (r_seed),
    .adv     (w_xfer && (r_mode == MODE_LFSR)),
    .bit_out (w_lfsr_bit)
  );

  // Outputs decode registered state only; ready/start never reach them.
  assign epsilon_vld     = w_run;
  assign epsilon_rsc_dat = w_run & w_bit;
  assign block_last      = w_run & w_last;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);
  assign ones_count      = r_ones;

endmodule

`default_nettype wire

// File: doc/epsilon_stream_gen.md
# epsilon_stream_gen

Bitstream source that produces the `epsilon` sequence consumed by the monobit frequency tester. It emits one block of `BLOCK_LEN` bits per `start` request, from a selectable pattern: 16-bit LFSR, all-zeros, all-ones or alternating. Alongside the bits it tracks the ones count of the emitted block, so the verdict from the tester downstream can be checked on-chip. It sits between the top-level `ui_in` controls and the tester's `epsilon_rsc_dat` input.

## Interface
Parameters:
- `BLOCK_LEN`, default 128: bits per block; must be at least 2.
- `CNT_W`, default 8: width of `ones_count`; must satisfy 2^CNT_W > BLOCK_LEN.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: block request; sampled only in IDLE.
- `mode` input 2: pattern select, captured on accepted `start`. 0 = LFSR, 1 = zeros, 2 = ones, 3 = alternating.
- `seed` input 16: LFSR seed, captured on accepted `start`.
- `ready` input 1: consumer accepts the current bit.
- `epsilon_rsc_dat` output 1: current stream bit.
- `epsilon_vld` output 1: `epsilon_rsc_dat` is valid.
- `block_last` output 1: current bit is the final bit of the block.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse when the block is complete.
- `ones_count` output CNT_W: count of transferred ones; final value is valid while `done` is high.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD when `start`=1.
  - Capture `mode` and `seed`.
  - A seed of 16'h0000 is replaced by 16'hACE1.
- LOAD: initialise the pattern register, clear `ones_count` and clear the bit counter. Always -> RUN next cycle.
- RUN: `epsilon_vld`=1.
  - A transfer occurs on any cycle with `epsilon_vld`=1 and `ready`=1.
  - On each transfer: advance the pattern, increment the bit counter, and add `epsilon_rsc_dat` to `ones_count`.
  - On the transfer that carries `block_last`, go -> DONE.
- DONE: `done`=1 for exactly one cycle, `ones_count` holds its final value, then -> IDLE.
- Pattern generation:
  - LFSR: `epsilon_rsc_dat` = lfsr[0]. On transfer, lfsr <= {fb, lfsr[15:1]} with fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5] (x^16+x^14+x^13+x^11+1).
  - Zeros: constant 0.
  - Ones: constant 1.
  - Alternating: first bit 1, then toggles on each transfer.
- `block_last` = `epsilon_vld` and (bit counter == BLOCK_LEN-1).
- `start` is ignored outside IDLE, with no queuing. `mode` and `seed` changes outside IDLE have no effect.
- `ones_count` keeps its last value in IDLE until the next LOAD.

## Timing
- Reset values: `epsilon_rsc_dat`=0, `epsilon_vld`=0, `block_last`=0, `busy`=0, `done`=0, `ones_count`=0; state IDLE; lfsr=16'hACE1.
- Reset has priority over every other input in every state. `rst` mid-RUN aborts the block, outputs return to reset values the next cycle, and no `done` is issued.
- Latency:
  - `start` in cycle T -> LOAD at T+1 -> first valid bit at T+2.
  - With `ready` held high, the last bit is at T+1+BLOCK_LEN and `done` is at T+2+BLOCK_LEN.
  - `start` can be accepted again at T+3+BLOCK_LEN.
- Backpressure: while `epsilon_vld`=1 and `ready`=0, `epsilon_rsc_dat`, `block_last`, the pattern and the counters hold. Throughput is one bit per cycle when `ready`=1.
- `ready` is don't-care outside RUN.
- All outputs are registered or decoded from registered state only. There is no combinational path from `ready` or `start` to any output.

## Structure
- Shared package `epsilon_pkg` holds:
  - the state enum;
  - mode constants MODE_LFSR=0, MODE_ZERO=1, MODE_ONE=2, MODE_ALT=3;
  - LFSR_DEFAULT_SEED=16'hACE1;
  - the LFSR tap positions.
- Sub-module `epsilon_lfsr16` contains only the LFSR. Ports: `clk`, `rst`, `load`, `seed`, `adv`, `bit_out`.
- The FSM, counters and mode multiplexing stay in the top module.

## Test plan
- Mode 1, `start` pulse, `ready`=1: 128 zeros, `block_last` on bit 127 only, `done` at T+130, `ones_count`=0.
- Mode 2: 128 ones, `ones_count`=128. Mode 3: bits 1,0,1,0…, `ones_count`=64.
- Mode 0 with seed 16'hACE1, then with seed 16'h0000:
  - both runs produce identical streams;
  - first two bits are 1, 0; lfsr is 16'h5670 after the first transfer;
  - `ones_count` matches a reference-model count.
- Backpressure: `ready` low for 5 cycles at bit 10. Bit 10 holds stable, no counter change, and the total stream equals the no-stall stream.
- `rst` asserted at bit 50 of RUN: the next cycle shows IDLE with all outputs at reset values and no `done`. A following `start` yields a full fresh block.
- `start` held high continuously: blocks run back-to-back with exactly one IDLE cycle after each `done`. A `start` pulse during RUN has no effect.
